// File: rtl/ctl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
// Also holds the branch-resolution helper used to drive the PC mux.
package ctl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [2:0] PC_SEQ          = 3'b000;
  localparam int         PCSRC_COND_BIT  = 2;
  localparam logic [3:0] DEFAULT_HALT_OP = 4'hF;

  // A zero-conditional branch falls through to the sequential PC when Z is clear.
  function automatic logic [2:0] resolve_pc_sel(input logic [2:0] pcsrc, input logic z);
    if (pcsrc[PCSRC_COND_BIT] && !z) begin
      return PC_SEQ;
    end else begin
      return pcsrc;
    end
  endfunction

endpackage

// File: rtl/control_sequencer_retire_counter.sv
// Retired-instruction counter: free-running modulo 2^CNT_W, no saturation.
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  // Count one per completed instruction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (i_en) begin
      o_count <= o_count + CNT_W'(1);
    end else begin
      o_count <= o_count;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a shared
// instruction/data memory handshake, zero-conditional branches and halt.
module control_sequencer
  import ctl_pkg::*;
#(
  parameter logic [3:0] HALT_OP = DEFAULT_HALT_OP,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [3:0]       ulasrc_i,
  input  logic [2:0]       pcsrc_i,
  input  logic             imm_i,
  input  logic             regsrc_i,
  input  logic             mw_i,
  input  logic             rw_i,
  input  logic             flag_z,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic [3:0]       ulasrc_o,
  output logic             imm_o,
  output logic             rf_src,
  output logic             rf_we,
  output logic             pc_we,
  output logic [2:0]       pc_sel,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t     r_state;
  state_t     w_next;
  logic       w_final;
  logic [3:0] r_ulasrc;
  logic [2:0] r_pcsrc;
  logic       r_imm;
  logic       r_regsrc;
  logic       r_mw;
  logic       r_rw;
  logic       r_z;
  logic       r_halted;

  // State register, decoder-field latches, Z sample and halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FETCH;
      r_ulasrc <= 4'h0;
      r_pcsrc  <= 3'b000;
      r_imm    <= 1'b0;
      r_regsrc <= 1'b0;
      r_mw     <= 1'b0;
      r_rw     <= 1'b0;
      r_z      <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == HALT);
      if (r_state == DECODE) begin
        r_ulasrc <= ulasrc_i;
        r_pcsrc  <= pcsrc_i;
        r_imm    <= imm_i;
        r_regsrc <= regsrc_i;
        r_mw     <= mw_i;
        r_rw     <= rw_i;
      end
      if (r_state == EXEC) begin
        r_z <= flag_z;
      end
    end
  end

  // Next state and strobes; ir_we and the MEM final-cycle pc_we follow mem_ready.
  always_comb begin
    w_next       = r_state;
    w_final      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    rf_we        = 1'b0;
    if (rst) begin
      w_next = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we  = 1'b1;
            w_next = DECODE;
          end else begin
            w_next = FETCH;
          end
        end
        DECODE: begin
          w_next = (opcode == HALT_OP) ? HALT : EXEC;
        end
        EXEC: begin
          if (r_mw || r_regsrc) begin
            w_next = MEM;
          end else if (r_rw) begin
            w_next = WB;
          end else begin
            w_final = 1'b1;
            w_next  = FETCH;
          end
        end
        MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = r_mw;
          if (mem_ready && r_rw) begin
            w_next = WB;
          end else if (mem_ready) begin
            w_final = 1'b1;
            w_next  = FETCH;
          end else begin
            w_next = MEM;
          end
        end
        WB: begin
          rf_we   = 1'b1;
          w_final = 1'b1;
          w_next  = FETCH;
        end
        HALT: begin
          w_next = HALT;
        end
        default: begin
          w_next = FETCH;
        end
      endcase
    end
  end

  assign pc_we    = w_final;
  assign pc_sel   = resolve_pc_sel(r_pcsrc, r_z);
  assign ulasrc_o = r_ulasrc;
  assign imm_o    = r_imm;
  assign rf_src   = r_regsrc;
  assign halted   = r_halted;

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (w_final),
    .o_count (retired)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against an
// instruction-level timing model (cycle counts per instruction class).
module tb_control_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       opcode = 4'h0;
  logic [3:0]       ulasrc_i = 4'h0;
  logic [2:0]       pcsrc_i = 3'b000;
  logic             imm_i = 1'b0, regsrc_i = 1'b0, mw_i = 1'b0, rw_i = 1'b0;
  logic             flag_z = 1'b0, mem_ready = 1'b0;
  logic             mem_req, mem_we, mem_addr_sel, ir_we, imm_o, rf_src, rf_we, pc_we, halted;
  logic [3:0]       ulasrc_o;
  logic [2:0]       pc_sel;
  logic [CNT_W-1:0] retired;

  control_sequencer #(.HALT_OP(4'hF), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .ulasrc_i(ulasrc_i), .pcsrc_i(pcsrc_i),
    .imm_i(imm_i), .regsrc_i(regsrc_i), .mw_i(mw_i), .rw_i(rw_i), .flag_z(flag_z),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .ulasrc_o(ulasrc_o), .imm_o(imm_o), .rf_src(rf_src), .rf_we(rf_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int model_retired = 0;
  int req_wait = 0;
  int cyc, pc_cyc, n_ir, n_rf, rf_last, n_mwe, n_dsel;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic begin_instr();
    cyc = 0; pc_cyc = -1; n_ir = 0; n_rf = 0; rf_last = -1; n_mwe = 0; n_dsel = 0;
  endtask

  // One clock cycle as the memory and ALU see it; entered and left at posedge+1.
  task automatic step(input int fw, input int mwt, input int zc, input bit z);
    flag_z = (cyc == zc) ? z : 1'($urandom);
    if (mem_req) mem_ready = (req_wait == (mem_addr_sel ? mwt : fw));
    else         mem_ready = 1'($urandom);
    #1;
    if (mem_req) req_wait = mem_ready ? 0 : req_wait + 1;
    n_ir   += int'(ir_we);
    n_rf   += int'(rf_we);
    n_mwe  += int'(mem_we);
    n_dsel += int'(mem_req & mem_addr_sel);
    if (rf_we) rf_last = cyc;
    if (pc_we && pc_cyc < 0) pc_cyc = cyc;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      #1;
      chk("rst_strobes", {27'd0, mem_req, mem_we, ir_we, rf_we, pc_we}, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0; mem_ready = 1'b0; req_wait = 0; model_retired = 0;
    #1;
    chk("rst_fetch_req", {30'd0, mem_req, mem_addr_sel}, 32'd2);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_halted_pcsel", {28'd0, halted, pc_sel}, 32'd0);
    #0;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [3:0] alu, input logic [2:0] pcs,
                           input bit imm, input bit regsrc, input bit mw, input bit rw,
                           input bit z, input int fw, input int mwt);
    int exp_len;
    bit uses_mem;
    opcode = op; ulasrc_i = alu; pcsrc_i = pcs; imm_i = imm; regsrc_i = regsrc; mw_i = mw; rw_i = rw;
    uses_mem = mw | regsrc;
    exp_len  = 3 + fw + (uses_mem ? 1 + mwt : 0) + (rw ? 1 : 0);
    begin_instr();
    while (pc_cyc < 0 && cyc < exp_len + 10) step(fw, mwt, fw + 2, z);
    model_retired = (model_retired + 1) % (1 << CNT_W);
    chk("latency", 32'(pc_cyc + 1), 32'(exp_len));
    chk("ir_we_count", 32'(n_ir), 32'd1);
    chk("rf_we_count", 32'(n_rf), rw ? 32'd1 : 32'd0);
    if (rw) chk("rf_we_last", 32'(rf_last), 32'(exp_len - 1));
    chk("mem_we_cycles", 32'(n_mwe), mw ? 32'(1 + mwt) : 32'd0);
    chk("data_addr_cycles", 32'(n_dsel), uses_mem ? 32'(1 + mwt) : 32'd0);
    chk("retired", 32'(retired), 32'(model_retired));
    chk("pc_sel", 32'(pc_sel), (pcs[2] && !z) ? 32'd0 : 32'(pcs));
    chk("static_fields", {26'd0, ulasrc_o, imm_o, rf_src}, {26'd0, alu, imm, regsrc});
  endtask

  task automatic run_halt(input int fw);
    opcode = 4'hF;
    begin_instr();
    for (int i = 0; i < fw + 2; i++) step(fw, 0, -1, 1'b0);
    chk("halted", 32'(halted), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("halt_quiet", {29'd0, mem_req, pc_we, ir_we}, 32'd0);
      step(fw, 0, -1, 1'b0);
    end
    chk("halt_still", 32'(halted), 32'd1);
    chk("halt_retired", 32'(retired), 32'(model_retired));
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset(3);
    // ALU + write, load with 2-cycle data wait, store, then branches on Z=1 and Z=0.
    run_instr(4'h1, 4'h3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    run_instr(4'h2, 4'h5, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2);
    run_instr(4'h3, 4'h0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0);
    run_instr(4'h4, 4'h1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    run_instr(4'h4, 4'h1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    // Halt after two instructions, then recover through reset.
    do_reset(1);
    run_instr(4'h1, 4'h2, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    run_instr(4'h5, 4'h7, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0);
    run_halt(1);
    do_reset(2);
    // Abandon a load in the middle of its data request.
    opcode = 4'h2; regsrc_i = 1'b1; rw_i = 1'b1; mw_i = 1'b0;
    begin_instr();
    for (int i = 0; i < 4; i++) step(0, 20, 2, 1'b0);
    chk("mid_mem_req", {30'd0, mem_req, mem_addr_sel}, 32'd3);
    do_reset(2);
    // Random program long enough to wrap the 4-bit retire counter.
    for (int k = 0; k < 40; k++) begin
      run_instr(4'($urandom_range(0, 14)), 4'($urandom), 3'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    run_halt(int'($urandom_range(0, 2)));
    do_reset(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control unit for the processor core. It fetches each instruction and hands the opcode to the ROM instruction decoder. It latches the decoder's control fields and sequences the ALU, data memory, register file and PC updates over FETCH/DECODE/EXEC/MEM/WB states. It also handles the shared instruction/data memory handshake, conditional branch resolution, halt, and a retired-instruction counter.

## Interface
- HALT_OP, 4'hF: opcode that stops the core.
- CNT_W, 16: width of the retired-instruction counter.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  current IR opcode; also feeds the decoder.
- ulasrc_i  in  4  decoder ALU-operation field.
- pcsrc_i  in  3  decoder PC-source field.
- imm_i, regsrc_i, mw_i, rw_i  in  1 each  decoder immediate-select, writeback-from-memory, memory-write and register-write flags.
- flag_z  in  1  ALU zero flag, valid during EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (store).
- mem_addr_sel  out  1  memory address source: 0 = PC, 1 = ALU/data address.
- ir_we  out  1  load IR.
- ulasrc_o  out  4  latched ALU operation.
- imm_o  out  1  latched immediate select.
- rf_src  out  1  latched regsrc (1 = memory data).
- rf_we  out  1  register-file write.
- pc_we  out  1  PC update.
- pc_sel  out  3  PC mux select.
- halted  out  1  core stopped.
- retired  out  CNT_W  count of completed instructions.

## Operation
- FETCH
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - Wait for mem_ready. In the cycle mem_ready=1: ir_we=1, next state DECODE.
- DECODE (1 cycle)
  - Latch ulasrc_i, pcsrc_i, imm_i, regsrc_i, mw_i, rw_i into the field registers (_l).
  - If opcode==HALT_OP, go to HALT; otherwise go to EXEC.
- EXEC (1 cycle)
  - Sample flag_z into z_l.
  - If mw_l or regsrc_l, go to MEM.
  - Else if rw_l, go to WB.
  - Else this is the final cycle; go to FETCH.
- MEM
  - mem_req=1, mem_addr_sel=1, mem_we=mw_l.
  - Wait for mem_ready. On mem_ready: go to WB if rw_l, else this is the final cycle; go to FETCH.
- WB (1 cycle)
  - rf_we=1. Always the final cycle; go to FETCH.
- HALT
  - Absorbing state until rst. halted=1; all strobes are 0.
- Final cycle of every instruction
  - pc_we=1 and retired increments by 1.
  - retired wraps modulo 2^CNT_W with no saturation.
- pc_sel
  - pc_sel = 3'b000 (sequential) when pcsrc_l[2]=1 and z_l=0; otherwise pc_sel = pcsrc_l.
  - pcsrc_l[2] marks a branch conditional on zero.
- Static outputs: ulasrc_o, imm_o and rf_src are driven directly from the latched fields. They hold from DECODE+1 until the next DECODE.
- mem_ready is ignored outside FETCH and MEM.
- rst overrides every state, including a pending memory request. The memory must tolerate an abandoned request.

## Timing
- Reset: while rst=1, mem_req, mem_we, ir_we, rf_we and pc_we are forced to 0.
  - State ← FETCH; all field latches, z_l, retired and halted ← 0; pc_sel=0.
  - First mem_req appears in the cycle after rst falls.
- Latency with mem_ready tied high:
  - ALU-only, no write: 3 cycles.
  - ALU + register write: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each mem_ready wait cycle adds 1 cycle.
- Handshake: mem_req stays high and the address/write controls stay stable until the cycle with mem_ready=1 (inclusive).
  - mem_req drops in the cycle after completion, unless the next state is FETCH. Back-to-back requests are allowed.
- ir_we and the final-cycle pc_we in MEM/FETCH are combinational in mem_ready (Mealy). All other outputs depend on registered state only.
- pc_we and retired update at the same edge. retired is visible one cycle after the final cycle.
- Halt: halted=1 from the cycle after DECODE. The halt instruction is not counted in retired.

## Structure
- Shared package ctl_pkg:
  - state enum typedef (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - PC_SEQ=3'b000;
  - PCSRC_COND_BIT=2;
  - default HALT_OP.
- One natural sub-module, retire_counter (CNT_W-bit, enable, synchronous reset). Everything else is flat.

## Test plan
- Reset then an ALU op (ulasrc=4'h3, rw=1, pcsrc=0), mem_ready always 1
  - Expect: mem_req in cycle 1, ir_we in cycle 1, rf_we+pc_we in cycle 4, pc_sel=0, retired=1.
- Load (regsrc=1, rw=1) with mem_ready delayed 2 cycles in MEM
  - Expect: mem_addr_sel=1 and mem_we=0 held 3 cycles, rf_src=1, total 7 cycles.
- Store (mw=1, rw=0)
  - Expect: mem_we=1 only in MEM, pc_we on the mem_ready cycle, rf_we never asserted.
- Conditional branch pcsrc=3'b101
  - With flag_z=1: pc_sel=3'b101.
  - Repeated with flag_z=0: pc_sel=3'b000.
- opcode=4'hF after 2 instructions
  - Expect: halted=1, no further mem_req, retired=2.
  - rst releases back to FETCH with retired=0.
- rst asserted mid-MEM with mem_req high
  - Expect: strobes 0 during reset, FETCH afterwards.
- Counter wrap: with CNT_W=4, 16 retirements
  - Expect: retired=0.
